// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage (master) and memory (slave).
// One outstanding request; the address stays stable until the response arrives.
interface fetch_stage_if #(
  parameter int WIDTH = 32
);
  logic             IMemReq;
  logic [WIDTH-1:0] IMemAddr;
  logic [31:0]      IMemRData;
  logic             IMemValid;

  modport master (output IMemReq, output IMemAddr, input IMemRData, input IMemValid);
  modport slave  (input IMemReq, input IMemAddr, output IMemRData, output IMemValid);
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch with IF/ID register, one-entry skid buffer for decode stalls,
// and a KILL state that drains a request made stale by a redirect.
module fetch_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       PCSrcE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] ImmExtE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  fetch_stage_if.master    imem,
  output logic [WIDTH-1:0] PCF,
  output logic [31:0]      InstrD,
  output logic [WIDTH-1:0] PCD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic             ValidD
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_KILL} state_t;

  function automatic logic [WIDTH-1:0] add_wrap(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  function automatic logic [WIDTH-1:0] jalr_target(input logic [WIDTH-1:0] sum);
    return {sum[WIDTH-1:1], 1'b0};
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_pcf;
  logic [WIDTH-1:0] r_req_addr;
  logic             r_pending;
  logic [31:0]      r_instrd;
  logic [WIDTH-1:0] r_pcd;
  logic [WIDTH-1:0] r_pcp4d;
  logic             r_validd;
  logic [31:0]      r_skid_instr;
  logic [WIDTH-1:0] r_skid_pc;

  logic             w_redirect;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_pcf_plus4;
  logic [WIDTH-1:0] w_req_plus4;
  logic             w_req;
  logic             w_resp;

  assign w_redirect  = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
  assign w_target    = (PCSrcE == 2'b10) ? jalr_target(ALUResultE) : add_wrap(PCE, ImmExtE);
  assign w_pcf_plus4 = add_wrap(r_pcf, WIDTH'(4));
  assign w_req_plus4 = add_wrap(r_req_addr, WIDTH'(4));

  // A pending request must stay asserted even under StallF; reset forces it low at once.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_FETCH: w_req = r_pending | ~StallF;
      S_KILL:  w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
    if (!RST) w_req = 1'b0;
  end

  assign w_resp = w_req & imem.IMemValid;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= S_FETCH;
      r_pcf        <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_pending    <= 1'b0;
      r_instrd     <= NOP_INSTR;
      r_pcd        <= '0;
      r_pcp4d      <= '0;
      r_validd     <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= '0;
    end else begin
      r_pending <= w_req & ~imem.IMemValid;
      if (w_redirect) begin
        r_pcf    <= w_target;
        r_instrd <= NOP_INSTR;
        r_validd <= 1'b0;
        if (w_req && !imem.IMemValid) begin
          r_state <= S_KILL;
        end else begin
          r_req_addr <= w_target;
          r_state    <= S_FETCH;
        end
      end else begin
        // IF/ID: flush beats stall, stall beats load; otherwise an idle cycle becomes a bubble.
        if (FlushD) begin
          r_instrd <= NOP_INSTR;
          r_validd <= 1'b0;
        end else if (!StallD) begin
          if (r_state == S_HOLD) begin
            r_instrd <= r_skid_instr;
            r_pcd    <= r_skid_pc;
            r_pcp4d  <= add_wrap(r_skid_pc, WIDTH'(4));
            r_validd <= 1'b1;
          end else if (r_state == S_FETCH && w_resp) begin
            r_instrd <= imem.IMemRData;
            r_pcd    <= r_req_addr;
            r_pcp4d  <= w_req_plus4;
            r_validd <= 1'b1;
          end else begin
            r_instrd <= NOP_INSTR;
            r_validd <= 1'b0;
          end
        end

        case (r_state)
          S_FETCH: begin
            if (w_resp) begin
              if (StallD && !FlushD) begin
                r_skid_instr <= imem.IMemRData;
                r_skid_pc    <= r_req_addr;
                r_state      <= S_HOLD;
              end
              if (!StallF) begin
                r_pcf      <= w_pcf_plus4;
                r_req_addr <= w_pcf_plus4;
              end
            end
          end
          S_HOLD: begin
            if (FlushD || !StallD) r_state <= S_FETCH;
          end
          S_KILL: begin
            if (w_resp) begin
              r_req_addr <= r_pcf;
              r_state    <= S_FETCH;
            end
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  assign imem.IMemReq  = w_req;
  assign imem.IMemAddr = r_req_addr;
  assign PCF           = r_pcf;
  assign InstrD        = r_instrd;
  assign PCD           = r_pcd;
  assign PCPlus4D      = r_pcp4d;
  assign ValidD        = r_validd;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-programmable memory model, in-order scoreboard of
// accepted fetches against IF/ID, a redirect-arithmetic vector table, and stall/kill/reset sequences.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam int          WIDTH = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [1:0]  PCSrcE = 2'b00;
  logic [31:0] PCE = '0, ImmExtE = '0, ALUResultE = '0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_stage_if #(.WIDTH(WIDTH)) imem ();

  fetch_stage #(.WIDTH(WIDTH), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .CLK(CLK), .RST(RST), .PCSrcE(PCSrcE), .PCE(PCE), .ImmExtE(ImmExtE),
    .ALUResultE(ALUResultE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .imem(imem), .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h0050_0093;
    else if (a == 32'h4) return 32'h00A0_0113;
    else                 return {a[24:0], 7'h13};
  endfunction

  // Memory model: responds once the request has been held for lat cycles (0 = same cycle).
  int lat = 0;
  int lat_cnt;
  assign imem.IMemValid = imem.IMemReq && (lat_cnt >= lat);
  assign imem.IMemRData = mem_word(imem.IMemAddr);
  always @(posedge CLK or negedge RST) begin
    if (!RST) lat_cnt <= 0;
    else if (imem.IMemReq && !imem.IMemValid) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
  end

  // Scoreboard: push each response the stage should keep, pop when IF/ID loads a real instruction.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  bit   killing   = 1'b0;
  bit   prev_load = 1'b0;
  bit   redir;

  always @(negedge CLK) begin
    if (!RST) begin
      q.delete();
      killing   = 1'b0;
      prev_load = 1'b0;
    end else begin
      if (prev_load && ValidD) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%h expected=none at %0t", InstrD, $time);
        end else begin
          e = q.pop_front();
          chk("sb_instr", InstrD, e.instr);
          chk("sb_pcd", PCD, e.pc);
          chk("sb_pcp4", PCPlus4D, e.pc + 32'd4);
        end
      end
      redir = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
      if (redir || FlushD) q.delete();
      if (imem.IMemReq && imem.IMemValid && !redir && !FlushD && !killing)
        q.push_back('{instr: mem_word(imem.IMemAddr), pc: imem.IMemAddr});
      if (imem.IMemReq && !imem.IMemValid && redir) killing = 1'b1;
      else if (imem.IMemValid) killing = 1'b0;
      prev_load = !StallD && !FlushD && !redir;
    end
  end

  typedef struct {
    logic [1:0]  src;
    logic [31:0] pce;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] exp_pcf;
    logic        exp_valid;
  } vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{2'b01, 32'h0000_0010, 32'hFFFF_FFF8, 32'h0,         32'h0000_0008, 1'b0};
    vt[1] = '{2'b00, 32'h0,         32'h0,         32'h0,         32'h0000_000C, 1'b1};
    vt[2] = '{2'b10, 32'h0,         32'h0,         32'h0000_0103, 32'h0000_0102, 1'b0};
    vt[3] = '{2'b11, 32'h0000_0200, 32'h0000_0040, 32'h0000_0301, 32'h0000_0106, 1'b1};
    vt[4] = '{2'b01, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0,         32'h0000_0004, 1'b0};
    vt[5] = '{2'b10, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vt[6] = '{2'b00, 32'h0,         32'h0,         32'h0,         32'h0000_0002, 1'b1};
    vt[7] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b0};

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req", 32'(imem.IMemReq), 32'h0);
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_addr", imem.IMemAddr, 32'h0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_valid", 32'(ValidD), 32'h0);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pcp4", PCPlus4D, 32'h0);

    // Release reset, zero-latency memory
    RST = 1'b1;
    #1;
    chk("c1_req", 32'(imem.IMemReq), 32'h1);
    chk("c1_addr", imem.IMemAddr, 32'h0);
    @(posedge CLK); #1;
    chk("c2_instr", InstrD, 32'h0050_0093);
    chk("c2_pcd", PCD, 32'h0);
    chk("c2_pcp4", PCPlus4D, 32'h4);
    chk("c2_valid", 32'(ValidD), 32'h1);
    @(posedge CLK); #1;
    chk("c3_pcd", PCD, 32'h4);
    chk("c3_instr", InstrD, 32'h00A0_0113);

    // Redirect arithmetic table
    for (int i = 0; i < 8; i++) begin
      PCSrcE = vt[i].src; PCE = vt[i].pce; ImmExtE = vt[i].imm; ALUResultE = vt[i].alu;
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_pcf", i), PCF, vt[i].exp_pcf);
      chk($sformatf("vec%0d_addr", i), imem.IMemAddr, vt[i].exp_pcf);
      chk($sformatf("vec%0d_valid", i), 32'(ValidD), 32'(vt[i].exp_valid));
      if (!vt[i].exp_valid) chk($sformatf("vec%0d_nop", i), InstrD, NOP);
    end
    PCSrcE = 2'b00;

    // StallF with nothing pending: no request, PC held
    StallF = 1'b1;
    #1;
    chk("stallf_req", 32'(imem.IMemReq), 32'h0);
    @(posedge CLK); #1;
    chk("stallf_pcf", PCF, 32'h0);
    chk("stallf_addr", imem.IMemAddr, 32'h0);
    chk("stallf_valid", 32'(ValidD), 32'h0);
    StallF = 1'b0;

    // Redirect while a 3-cycle request is outstanding
    PCSrcE = 2'b01; PCE = 32'h100; ImmExtE = 32'h0;
    @(posedge CLK); #1;
    chk("k0_addr", imem.IMemAddr, 32'h100);
    lat = 3;
    PCE = 32'h40;
    #1;
    chk("k0_req", 32'(imem.IMemReq), 32'h1);
    @(posedge CLK); #1;
    PCSrcE = 2'b00;
    chk("k1_pcf", PCF, 32'h40);
    chk("k1_addr", imem.IMemAddr, 32'h100);
    chk("k1_req", 32'(imem.IMemReq), 32'h1);
    chk("k1_valid", 32'(ValidD), 32'h0);
    @(posedge CLK); #1;
    chk("k2_addr", imem.IMemAddr, 32'h100);
    chk("k2_valid", 32'(ValidD), 32'h0);
    @(posedge CLK); #1;
    chk("k3_addr", imem.IMemAddr, 32'h100);
    lat = 0;
    @(posedge CLK); #1;
    chk("k4_addr", imem.IMemAddr, 32'h40);
    chk("k4_valid", 32'(ValidD), 32'h0);
    @(posedge CLK); #1;
    chk("k5_instr", InstrD, mem_word(32'h40));
    chk("k5_pcd", PCD, 32'h40);

    // Decode stall across a response: skid buffer, HOLD, then release
    StallD = 1'b1;
    @(posedge CLK); #1;
    chk("h1_req", 32'(imem.IMemReq), 32'h0);
    chk("h1_instr", InstrD, mem_word(32'h40));
    chk("h1_pcd", PCD, 32'h40);
    chk("h1_valid", 32'(ValidD), 32'h1);
    @(posedge CLK); #1;
    chk("h2_req", 32'(imem.IMemReq), 32'h0);
    chk("h2_instr", InstrD, mem_word(32'h40));
    StallD = 1'b0;
    @(posedge CLK); #1;
    chk("h3_instr", InstrD, mem_word(32'h44));
    chk("h3_pcd", PCD, 32'h44);
    chk("h3_pcp4", PCPlus4D, 32'h48);
    chk("h3_addr", imem.IMemAddr, 32'h48);
    chk("h3_req", 32'(imem.IMemReq), 32'h1);
    @(posedge CLK); #1;
    chk("h4_pcd", PCD, 32'h48);

    // FlushD together with StallD
    StallD = 1'b1; FlushD = 1'b1;
    @(posedge CLK); #1;
    StallD = 1'b0; FlushD = 1'b0;
    chk("fl_valid", 32'(ValidD), 32'h0);
    chk("fl_instr", InstrD, NOP);
    chk("fl_pcf", PCF, 32'h50);
    @(posedge CLK); #1;
    chk("fl_next_pcd", PCD, 32'h50);

    // Reset pulse while a request waits
    lat = 3;
    @(posedge CLK);
    #4 RST = 1'b0;
    #1;
    chk("mr_req", 32'(imem.IMemReq), 32'h0);
    chk("mr_pcf", PCF, 32'h0);
    chk("mr_addr", imem.IMemAddr, 32'h0);
    chk("mr_instr", InstrD, NOP);
    chk("mr_valid", 32'(ValidD), 32'h0);
    chk("mr_pcd", PCD, 32'h0);
    chk("mr_pcp4", PCPlus4D, 32'h0);
    lat = 0;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("mr_rel_req", 32'(imem.IMemReq), 32'h1);
    chk("mr_rel_addr", imem.IMemAddr, 32'h0);
    @(posedge CLK); #1;
    chk("mr_rel_instr", InstrD, 32'h0050_0093);

    // Drain: stop fetching and make sure every accepted fetch reached decode
    StallF = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("sb_drain", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
